// File: rtl/fetch_pc_controller.sv
// fetch_pc_controller
//   Instruction-fetch PC sequencer with a one-entry fetch buffer and a
//   one-entry skid register. Keeps at most one instruction-memory request
//   outstanding, follows redirects from execute, and drops any response that
//   belongs to a fetch made obsolete by a redirect.
//
// Handshake (memory side): while imem_req=1 the address is held stable; the
//   request completes in the cycle imem_rvalid=1 (which may be the same cycle
//   the request first appears). Decode side: the buffer entry is consumed in
//   every cycle with InstrValidF=1 and StallF=0.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   StallF           decode does not accept the buffered instruction
//   PCSrcE           redirect this cycle, target in PCTargetE (bits [1:0] ignored)
//   imem_req/addr    memory request and word-aligned address
//   imem_rvalid/rdata memory response
//   PCF, PCPlus4F    next PC to fetch and PCF+4
//   InstrF/InstrPCF/InstrValidF  fetch buffer contents
//   fsm_state        current FSM state (0=FETCH, 1=SKID, 2=DRAIN) for observation
module fetch_pc_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] InstrF,
  output logic [31:0] InstrPCF,
  output logic        InstrValidF,
  output logic [1:0]  fsm_state
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] PC_RESET = RESET_PC & ~32'h3;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    SKID  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        consume;

  assign target   = PCTargetE & ~32'h3;
  assign pc_plus4 = pc_q + 32'd4;
  assign consume  = valid_q && !StallF;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    case (state_q)
      FETCH: begin
        if (PCSrcE) begin
          pc_d    = target;
          valid_d = 1'b0;
          if (imem_rvalid) begin
            // Response completes now and is dropped; target fetch starts next cycle.
            req_addr_d = target;
            state_d    = FETCH;
          end else begin
            // Old request still in flight: keep its address until it returns.
            state_d = DRAIN;
          end
        end else if (imem_rvalid) begin
          pc_d       = pc_plus4;
          req_addr_d = pc_plus4;
          if (!valid_q || consume) begin
            instr_d    = imem_rdata;
            instr_pc_d = req_addr_q;
            valid_d    = 1'b1;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = req_addr_q;
            state_d      = SKID;
          end
        end else if (consume) begin
          valid_d = 1'b0;
        end
      end

      SKID: begin
        if (PCSrcE) begin
          // No request is outstanding in SKID, so the target is fetched directly.
          pc_d       = target;
          req_addr_d = target;
          valid_d    = 1'b0;
          state_d    = FETCH;
        end else if (!StallF) begin
          instr_d    = skid_instr_q;
          instr_pc_d = skid_pc_q;
          valid_d    = 1'b1;
          state_d    = FETCH;
        end
      end

      DRAIN: begin
        if (PCSrcE) begin
          pc_d = target;
        end
        if (PCSrcE || consume) begin
          valid_d = 1'b0;
        end
        if (imem_rvalid) begin
          // Stale response discarded; fetch resumes at the latest target.
          req_addr_d = PCSrcE ? target : pc_q;
          state_d    = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= PC_RESET;
      req_addr_q   <= PC_RESET;
      instr_q      <= NOP;
      instr_pc_q   <= 32'h0;
      valid_q      <= 1'b0;
      skid_instr_q <= NOP;
      skid_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  // The request is suppressed while rst is high so nothing is issued in the
  // reset cycle, even before the state register has been cleared.
  assign imem_req    = !rst && (state_q != SKID);
  assign imem_addr   = req_addr_q;
  assign PCF         = pc_q;
  assign PCPlus4F    = pc_plus4;
  assign InstrF      = instr_q;
  assign InstrPCF    = instr_pc_q;
  assign InstrValidF = valid_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_fetch_pc_controller.sv
// Directed bench for fetch_pc_controller. A small memory model answers each
// request after a programmable number of wait cycles with data = addr + 0x1000_0000.
module tb_fetch_pc_controller;

  logic        clk;
  logic        rst;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic [31:0] InstrF;
  logic [31:0] InstrPCF;
  logic        InstrValidF;
  logic [1:0]  fsm_state;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_SKID  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [31:0] DOFS   = 32'h1000_0000;

  int tests_run = 0;
  int tests_failed = 0;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_pc_controller #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrF(InstrF),
    .InstrPCF(InstrPCF), .InstrValidF(InstrValidF), .fsm_state(fsm_state)
  );

  // memory model: responds when the request has been held for 'lat' cycles
  int unsigned lat;
  int unsigned cnt;
  always_ff @(posedge clk) begin
    if (rst || !imem_req || imem_rvalid) cnt <= 0;
    else cnt <= cnt + 1;
  end
  assign imem_rvalid = imem_req && (cnt == lat);
  assign imem_rdata  = imem_addr + DOFS;

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_buf(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'b0, InstrValidF}, {31'b0, v});
    if (v) begin
      chk({tag, "_pc"}, InstrPCF, pc);
      chk({tag, "_instr"}, InstrF, pc + DOFS);
    end
  endtask

  initial begin
    rst = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0; lat = 0;
    tick();
    settle();
    // reset state
    chk("rst_pcf", PCF, 32'h0);
    chk("rst_valid", {31'b0, InstrValidF}, 32'h0);
    chk("rst_instr", InstrF, 32'h0000_0013);
    chk("rst_instrpc", InstrPCF, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_state", {30'b0, fsm_state}, {30'b0, S_FETCH});

    // single-cycle memory streaming: addresses 0,4,8 back to back
    rst = 1'b0;
    settle();
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    tick(); settle();
    chk("s1_addr", imem_addr, 32'h4);
    chk("s1_pcf", PCF, 32'h4);
    chk("s1_pcplus4", PCPlus4F, 32'h8);
    chk_buf("s1", 1'b1, 32'h0);
    tick(); settle();
    chk("s2_addr", imem_addr, 32'h8);
    chk_buf("s2", 1'b1, 32'h4);
    tick();
    StallF = 1'b1;              // buffer holds 0x8, response for 0xC arrives now
    settle();
    chk("s3_addr", imem_addr, 32'hC);
    chk_buf("s3", 1'b1, 32'h8);

    // stall with full buffer: response goes to skid
    for (int i = 0; i < 2; i++) begin
      tick(); settle();
      chk("skid_state", {30'b0, fsm_state}, {30'b0, S_SKID});
      chk("skid_req", {31'b0, imem_req}, 32'h0);
      chk_buf("skid_hold", 1'b1, 32'h8);
      chk("skid_pcf", PCF, 32'h10);
    end
    tick();
    StallF = 1'b0;
    lat = 3;
    settle();
    chk_buf("skid_last", 1'b1, 32'h8);
    tick(); settle();
    chk("unskid_state", {30'b0, fsm_state}, {30'b0, S_FETCH});
    chk_buf("unskid", 1'b1, 32'hC);
    chk("unskid_addr", imem_addr, 32'h10);
    chk("unskid_req", {31'b0, imem_req}, 32'h1);

    // latency 3, redirect one cycle after the request at 0x10
    tick();
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0102;
    settle();
    chk_buf("pre_redir", 1'b0, 32'h0);
    chk("pre_redir_addr", imem_addr, 32'h10);
    tick();
    PCSrcE = 1'b0;
    settle();
    chk("drain_state", {30'b0, fsm_state}, {30'b0, S_DRAIN});
    chk("drain_addr", imem_addr, 32'h10);
    chk("drain_req", {31'b0, imem_req}, 32'h1);
    chk("drain_pcf", PCF, 32'h100);
    chk_buf("drain", 1'b0, 32'h0);
    tick(); settle();
    chk("drain2_state", {30'b0, fsm_state}, {30'b0, S_DRAIN});
    chk("drain2_addr", imem_addr, 32'h10);
    tick(); settle();
    chk("postdrain_state", {30'b0, fsm_state}, {30'b0, S_FETCH});
    chk("postdrain_addr", imem_addr, 32'h100);
    chk_buf("postdrain", 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      chk("wait100_addr", imem_addr, 32'h100);
      chk_buf("wait100", 1'b0, 32'h0);
    end
    tick();
    // redirect coinciding with a response while stalled with a full buffer
    lat = 0; StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h0000_0200;
    settle();
    chk_buf("got100", 1'b1, 32'h100);
    chk("coinc_addr", imem_addr, 32'h104);
    tick();
    StallF = 1'b0; PCSrcE = 1'b0;
    settle();
    chk("coinc_state", {30'b0, fsm_state}, {30'b0, S_FETCH});
    chk_buf("coinc_clear", 1'b0, 32'h0);
    chk("coinc_addr2", imem_addr, 32'h200);
    chk("coinc_pcf", PCF, 32'h200);
    tick();
    // redirect to the last word; low target bits must be ignored
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFF;
    settle();
    chk_buf("got200", 1'b1, 32'h200);
    tick();
    PCSrcE = 1'b0;
    settle();
    chk("wrap_pcf", PCF, 32'hFFFF_FFFC);
    chk("wrap_pcplus4", PCPlus4F, 32'h0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    StallF = 1'b1;             // next response (addr 0) will go to skid
    settle();
    chk("wrapped_pcf", PCF, 32'h0);
    chk("wrapped_pcplus4", PCPlus4F, 32'h4);
    chk_buf("wrapped", 1'b1, 32'hFFFF_FFFC);

    // redirect out of SKID
    tick();
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0300;
    settle();
    chk("skid2_state", {30'b0, fsm_state}, {30'b0, S_SKID});
    tick();
    PCSrcE = 1'b0; StallF = 1'b0;
    settle();
    chk("skidredir_state", {30'b0, fsm_state}, {30'b0, S_FETCH});
    chk("skidredir_addr", imem_addr, 32'h300);
    chk("skidredir_req", {31'b0, imem_req}, 32'h1);
    chk_buf("skidredir", 1'b0, 32'h0);
    tick();
    lat = 3; PCSrcE = 1'b1; PCTargetE = 32'h0000_0400;
    settle();
    chk_buf("got300", 1'b1, 32'h300);

    // reset while draining
    tick();
    PCSrcE = 1'b0;
    settle();
    chk("drain3_state", {30'b0, fsm_state}, {30'b0, S_DRAIN});
    rst = 1'b1;
    settle();
    chk("rstcyc_req", {31'b0, imem_req}, 32'h0);
    tick();
    settle();
    chk("rst2_pcf", PCF, 32'h0);
    chk("rst2_valid", {31'b0, InstrValidF}, 32'h0);
    chk("rst2_state", {30'b0, fsm_state}, {30'b0, S_FETCH});
    chk("rst2_req", {31'b0, imem_req}, 32'h0);
    rst = 1'b0;
    settle();
    chk("rel2_req", {31'b0, imem_req}, 32'h1);
    chk("rel2_addr", imem_addr, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_pc_controller.md
FETCH_PC_CONTROLLER -- requirements
Module: fetch_pc_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded by reset; bits [1:0] are 0.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 StallF  input  1  SHALL mean the decode stage does not accept the buffered instruction this cycle.
REQ-005 PCSrcE  input  1  SHALL mean a taken branch or jump redirect this cycle.
REQ-006 PCTargetE  input  32  SHALL be the redirect target, valid when PCSrcE=1.
REQ-007 imem_req  output  1  SHALL be the instruction-memory request.
REQ-008 imem_addr  output  32  SHALL be the request address, word aligned.
REQ-009 imem_rvalid  input  1  SHALL mean imem_rdata holds the response; it may arrive in the same cycle as imem_req or later.
REQ-010 imem_rdata  input  32  SHALL be the fetched instruction word.
REQ-011 PCF  output  32  SHALL be the next PC to be fetched.
REQ-012 PCPlus4F  output  32  SHALL be PCF+4, combinational, modulo 2^32.
REQ-013 InstrF / InstrPCF / InstrValidF  output  32/32/1  SHALL be the one-entry fetch buffer: instruction, its PC, and its valid bit.

Function
REQ-014 States SHALL be FETCH, SKID and DRAIN; the next PC SHALL be PCF+4 modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-015 The buffer SHALL be consumed in any cycle with InstrValidF=1 and StallF=0.
REQ-016 FETCH: imem_req=1 and imem_addr=ReqAddr, where ReqAddr is latched from PCF when a request starts; imem_req and imem_addr SHALL stay stable until imem_rvalid.
REQ-017 FETCH with imem_rvalid and the buffer empty or consumed: the buffer SHALL load {imem_rdata, ReqAddr}, InstrValidF<=1, PCF<=PCF+4, and the state SHALL stay FETCH with the next request starting the following cycle.
REQ-018 FETCH with imem_rvalid, the buffer full and StallF=1: the response SHALL go to a skid register, PCF<=PCF+4, and the state SHALL become SKID.
REQ-019 SKID: imem_req=0; when StallF=0 the buffer SHALL load the skid contents and the state SHALL become FETCH; otherwise everything SHALL hold.
REQ-020 Buffer consumed with no new load: InstrValidF<=0 next cycle.
REQ-021 A redirect (PCSrcE=1) SHALL take priority over StallF and all other events.
  - PCF SHALL take {PCTargetE[31:2],2'b00}; PCTargetE[1:0] is ignored.
  - InstrValidF and the skid SHALL be cleared next cycle.
REQ-022 Redirect in FETCH with no imem_rvalid: the state SHALL become DRAIN.
REQ-023 Redirect in FETCH with imem_rvalid in the same cycle: the response SHALL be discarded and the state SHALL be FETCH, fetching the target next cycle.
REQ-024 DRAIN: imem_req=1 at the old ReqAddr until imem_rvalid; the response SHALL be discarded and the state SHALL become FETCH.
  - A further redirect in DRAIN SHALL update PCF only (last target wins).
REQ-025 Redirect in SKID: the state SHALL become FETCH at the target with no outstanding request.
REQ-026 At most one imem request SHALL be outstanding at any time; a discarded response SHALL never reach InstrF.

Reset
REQ-027 While rst=1 the block SHALL drive:
  - PCF=ReqAddr=RESET_PC, state=FETCH;
  - InstrValidF=0, InstrF=32'h0000_0013 (NOP), InstrPCF=0, skid empty;
  - imem_req=0 during the reset cycle.
REQ-028 In the first cycle after rst falls, imem_req SHALL be 1 with imem_addr=RESET_PC.
REQ-029 rst asserted mid-operation (SKID, DRAIN, outstanding request) SHALL abandon all state; any imem_rvalid during or after that reset for the abandoned request is outside this block's contract, and the memory SHALL be reset with it.

Verification
REQ-030 Reset release, single-cycle memory, StallF=0 -> imem_addr 0,4,8 on consecutive cycles; InstrPCF 0,4,8 one cycle later.
REQ-031 StallF=1 for 3 cycles with the buffer full and a response arriving -> SKID entered, imem_req=0, InstrF unchanged; StallF=0 -> the skid word appears next cycle, no word lost or duplicated.
REQ-032 Memory latency 3, PCSrcE=1 with PCTargetE=0x0000_0102 one cycle after the request at 0x10 -> DRAIN, imem_addr held at 0x10, response dropped, next request at 0x100, InstrValidF=0 until the 0x100 word.
REQ-033 PCSrcE=1 coinciding with imem_rvalid and StallF=1 -> response dropped, buffer cleared, next imem_addr=target.
REQ-034 PCF=0xFFFF_FFFC fetched -> PCF=0x0000_0000 and PCPlus4F=0x0000_0004.
REQ-035 rst asserted for one cycle while in DRAIN -> next cycle PCF=RESET_PC, InstrValidF=0; following cycle imem_req=1 at RESET_PC.
